// File: rtl/quadra_term_gen_pkg.sv
// Shared fixed-point types, shift constants and FSM encoding for the
// quadratic approximation term generator.
package quadra_term_gen_pkg;

  typedef logic        [15:0] x2_fxd_t;
  typedef logic signed [27:0] c0_fxd_t;
  typedef logic signed [19:0] c1_fxd_t;
  typedef logic signed [13:0] c2_fxd_t;
  typedef logic signed [27:0] t0_fxd_t;
  typedef logic signed [31:0] t1_fxd_t;
  typedef logic signed [29:0] t2_fxd_t;

  localparam int SQ_SHIFT = 16;
  localparam int T1_SHIFT = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQ   = 3'd1,
    LIN  = 3'd2,
    QUAD = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/quadra_mul_20x17.sv
// Combinational signed 20x17 multiplier, full 37-bit product.
module quadra_mul_20x17 (
  input  logic signed [19:0] a,
  input  logic signed [16:0] b,
  output logic signed [36:0] p
);

  assign p = 37'(a) * 37'(b);

endmodule

// File: rtl/quadra_term_gen.sv
// Sequential generator of t0=c0, t1=c1*x2, t2=c2*x2^2 using one shared
// multiplier over three cycles, with valid/ready on both sides.
module quadra_term_gen
  import quadra_term_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x2,
  input  logic [27:0] c0,
  input  logic [19:0] c1,
  input  logic [13:0] c2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [27:0] t0_fxd,
  output logic [31:0] t1_fxd,
  output logic [29:0] t2_fxd
);

  state_e  state_q, state_d;
  x2_fxd_t x2_q, x2_d;
  c1_fxd_t c1_q, c1_d;
  c2_fxd_t c2_q, c2_d;
  x2_fxd_t sq16_q, sq16_d;
  t0_fxd_t t0_q, t0_d;
  t1_fxd_t t1_q, t1_d;
  t2_fxd_t t2_q, t2_d;

  logic signed [19:0] mul_a;
  logic signed [16:0] mul_b;
  logic signed [36:0] prod;
  logic               accept;
  logic               unused_prod_msb;

  quadra_mul_20x17 u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

  assign unused_prod_msb = prod[36];

  assign in_ready  = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign t0_fxd    = t0_q;
  assign t1_fxd    = t1_q;
  assign t2_fxd    = t2_q;

  always_comb begin
    state_d = state_q;
    x2_d    = x2_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
    sq16_d  = sq16_q;
    t0_d    = t0_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    mul_a   = '0;
    mul_b   = '0;

    case (state_q)
      IDLE: ;
      SQ: begin
        mul_a   = {4'b0000, x2_q};
        mul_b   = {1'b0, x2_q};
        sq16_d  = prod[SQ_SHIFT +: 16];
        state_d = LIN;
      end
      LIN: begin
        mul_a   = c1_q;
        mul_b   = {1'b0, x2_q};
        t1_d    = prod[T1_SHIFT +: 32];
        state_d = QUAD;
      end
      QUAD: begin
        mul_a   = {{6{c2_q[13]}}, c2_q};
        mul_b   = {1'b0, sq16_q};
        t2_d    = prod[29:0];
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A handshake can only happen in IDLE or in DONE while the bundle leaves.
    if (accept) begin
      x2_d    = x2;
      c1_d    = c1;
      c2_d    = c2;
      t0_d    = c0;
      state_d = SQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x2_q    <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      sq16_q  <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
    end else begin
      state_q <= state_d;
      x2_q    <= x2_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      sq16_q  <= sq16_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
    end
  end

endmodule
